controlador_de_luzes_multifaixa: RTL and testbench

//  Per-lane entry/alert light controller for N access lanes. Each lane filters its external sensor,

---
 rtl/pacote_luzes_pkg.sv | 13 +
 rtl/controlador_de_luzes_multifaixa_if.sv | 38 +++
 rtl/filtro_sensor.sv | 44 ++++
 rtl/controlador_de_luzes_multifaixa.sv | 111 +++++++++++
 tb/tb_controlador_de_luzes_multifaixa.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pacote_luzes_pkg.sv
// Shared constants for the multi-lane light controller: lane state encoding and
// the width of each lane's block-event counter.
package pacote_luzes_pkg;

    localparam logic [2:0] ST_INATIVO    = 3'd0;
    localparam logic [2:0] ST_PASSAGEM   = 3'd1;
    localparam logic [2:0] ST_VIGILANCIA = 3'd2;
    localparam logic [2:0] ST_BLOQUEIO   = 3'd3;
    localparam logic [2:0] ST_FALHA      = 3'd4;

    localparam int LARGURA_CONTAGEM = 8;

endpackage

// File: rtl/controlador_de_luzes_multifaixa_if.sv
// Lane sensor / lamp bus of the multi-lane light controller.
// CONTAGEM_BLOQUEIOS exists only when CONTADOR_DE_BLOQUEIOS_EN is defined.
interface controlador_de_luzes_multifaixa_if
    import pacote_luzes_pkg::*;
#(
    parameter int N_FAIXAS = 2
);
    logic                ON_OFF;
    logic [N_FAIXAS-1:0] SENSOR_EXTERNO;
    logic [N_FAIXAS-1:0] NOVA_PASSAGEM;
    logic [N_FAIXAS-1:0] STATUS_DE_ENTRADA_LIBERADA;
    logic [N_FAIXAS-1:0] STATUS_DE_ESTRADA_BLOQUEADA;
    logic [N_FAIXAS-1:0] STATUS_DE_FALHA;
    logic                ALGUM_BLOQUEIO;
    logic                ALGUMA_FALHA;
`ifdef CONTADOR_DE_BLOQUEIOS_EN
    logic [LARGURA_CONTAGEM*N_FAIXAS-1:0] CONTAGEM_BLOQUEIOS;
`endif

    modport master (
        output ON_OFF, SENSOR_EXTERNO, NOVA_PASSAGEM,
        input  STATUS_DE_ENTRADA_LIBERADA, STATUS_DE_ESTRADA_BLOQUEADA, STATUS_DE_FALHA,
        input  ALGUM_BLOQUEIO, ALGUMA_FALHA
`ifdef CONTADOR_DE_BLOQUEIOS_EN
        , input CONTAGEM_BLOQUEIOS
`endif
    );

    modport slave (
        input  ON_OFF, SENSOR_EXTERNO, NOVA_PASSAGEM,
        output STATUS_DE_ENTRADA_LIBERADA, STATUS_DE_ESTRADA_BLOQUEADA, STATUS_DE_FALHA,
        output ALGUM_BLOQUEIO, ALGUMA_FALHA
`ifdef CONTADOR_DE_BLOQUEIOS_EN
        , output CONTAGEM_BLOQUEIOS
`endif
    );

endinterface

// File: rtl/filtro_sensor.sv
// Two-flop synchroniser followed by a debounce counter: the filtered value follows the
// synchronised sensor only after it has disagreed for DEBOUNCE_CICLOS consecutive cycles.
module filtro_sensor #(
    parameter int DEBOUNCE_CICLOS = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_sensor,
    output logic o_filtrado
);
    localparam int LARG = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
    localparam logic [LARG-1:0] CONT_FIM = LARG'(DEBOUNCE_CICLOS - 1);

    logic            r_sinc_p0;
    logic            r_sinc_p1;
    logic            r_filtrado;
    logic [LARG-1:0] r_cont;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sinc_p0  <= 1'b0;
            r_sinc_p1  <= 1'b0;
            r_filtrado <= 1'b0;
            r_cont     <= '0;
        end else begin
            r_sinc_p0 <= i_sensor;
            r_sinc_p1 <= r_sinc_p0;
            // debounce stage: a single agreeing cycle restarts the count
            if (r_sinc_p1 != r_filtrado) begin
                if (r_cont == CONT_FIM) begin
                    r_filtrado <= r_sinc_p1;
                    r_cont     <= '0;
                end else begin
                    r_cont <= r_cont + LARG'(1);
                end
            end else begin
                r_cont <= '0;
            end
        end
    end

    assign o_filtrado = r_filtrado;

endmodule

// File: rtl/controlador_de_luzes_multifaixa.sv
// Per-lane entry/stop light controller with stuck-sensor fault detection.
// Optional macro CONTADOR_DE_BLOQUEIOS_EN adds a saturating per-lane block-event counter.
module controlador_de_luzes_multifaixa
    import pacote_luzes_pkg::*;
#(
    parameter int N_FAIXAS        = 2,
    parameter int DEBOUNCE_CICLOS = 4,
    parameter int TEMPO_LIMITE    = 16
) (
    input logic CLK,
    input logic RST,
    controlador_de_luzes_multifaixa_if.slave bus
);
    localparam int LARG_TEMPO = $clog2(TEMPO_LIMITE);
    localparam logic [LARG_TEMPO-1:0] TEMPO_FIM = LARG_TEMPO'(TEMPO_LIMITE - 1);

    logic [N_FAIXAS-1:0] w_liberada;
    logic [N_FAIXAS-1:0] w_bloqueada;
    logic [N_FAIXAS-1:0] w_falha;

`ifdef CONTADOR_DE_BLOQUEIOS_EN
    logic [N_FAIXAS-1:0][LARGURA_CONTAGEM-1:0] w_contagem;

    function automatic logic [LARGURA_CONTAGEM-1:0] incrementa_saturado(
        input logic [LARGURA_CONTAGEM-1:0] valor
    );
        return (&valor) ? valor : valor + LARGURA_CONTAGEM'(1);
    endfunction
`endif

    for (genvar g = 0; g < N_FAIXAS; g++) begin : g_faixa
        logic                  w_filtrado;
        logic [2:0]            r_estado;
        logic [LARG_TEMPO-1:0] r_tempo;

        filtro_sensor #(
            .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
        ) u_filtro (
            .CLK       (CLK),
            .RST       (RST),
            .i_sensor  (bus.SENSOR_EXTERNO[g]),
            .o_filtrado(w_filtrado)
        );

        // The fault check precedes the sensor-release check so the limit cycle always faults.
        always_ff @(posedge CLK) begin
            if (RST || !bus.ON_OFF) begin
                r_estado <= ST_INATIVO;
                r_tempo  <= '0;
            end else begin
                case (r_estado)
                    ST_INATIVO: r_estado <= ST_PASSAGEM;
                    ST_PASSAGEM: if (!w_filtrado) r_estado <= ST_VIGILANCIA;
                    ST_VIGILANCIA: begin
                        if (w_filtrado) begin
                            r_estado <= ST_BLOQUEIO;
                            r_tempo  <= '0;
                        end else if (bus.NOVA_PASSAGEM[g]) begin
                            r_estado <= ST_PASSAGEM;
                        end
                    end
                    ST_BLOQUEIO: begin
                        if (r_tempo == TEMPO_FIM) begin
                            r_estado <= ST_FALHA;
                            r_tempo  <= '0;
                        end else if (!w_filtrado) begin
                            r_estado <= ST_VIGILANCIA;
                            r_tempo  <= '0;
                        end else begin
                            r_tempo <= r_tempo + LARG_TEMPO'(1);
                        end
                    end
                    ST_FALHA: r_estado <= ST_FALHA;
                    default: begin
                        r_estado <= ST_INATIVO;
                        r_tempo  <= '0;
                    end
                endcase
            end
        end

        assign w_liberada[g]  = (r_estado == ST_PASSAGEM) || (r_estado == ST_VIGILANCIA);
        assign w_bloqueada[g] = (r_estado == ST_BLOQUEIO) || (r_estado == ST_FALHA);
        assign w_falha[g]     = (r_estado == ST_FALHA);

`ifdef CONTADOR_DE_BLOQUEIOS_EN
        logic [LARGURA_CONTAGEM-1:0] r_contagem;

        // Only RST clears the history; ON_OFF cycling keeps it.
        always_ff @(posedge CLK) begin
            if (RST) begin
                r_contagem <= '0;
            end else if (bus.ON_OFF && (r_estado == ST_VIGILANCIA) && w_filtrado) begin
                r_contagem <= incrementa_saturado(r_contagem);
            end
        end

        assign w_contagem[g] = r_contagem;
`endif
    end

    assign bus.STATUS_DE_ENTRADA_LIBERADA  = w_liberada;
    assign bus.STATUS_DE_ESTRADA_BLOQUEADA = w_bloqueada;
    assign bus.STATUS_DE_FALHA             = w_falha;
    assign bus.ALGUM_BLOQUEIO              = |w_bloqueada;
    assign bus.ALGUMA_FALHA                = |w_falha;
`ifdef CONTADOR_DE_BLOQUEIOS_EN
    assign bus.CONTAGEM_BLOQUEIOS          = w_contagem;
`endif

endmodule

// File: tb/tb_controlador_de_luzes_multifaixa.sv
// Directed bench for controlador_de_luzes_multifaixa (N_FAIXAS=2, DEBOUNCE_CICLOS=4, TEMPO_LIMITE=16).
module tb_controlador_de_luzes_multifaixa;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    controlador_de_luzes_multifaixa_if #(.N_FAIXAS(2)) bus ();

    controlador_de_luzes_multifaixa #(
        .N_FAIXAS       (2),
        .DEBOUNCE_CICLOS(4),
        .TEMPO_LIMITE   (16)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ON_OFF = 1'b1;
        bus.SENSOR_EXTERNO = 2'b00;
        bus.NOVA_PASSAGEM = 2'b00;
        tick(2);
        total++;
        if ({bus.STATUS_DE_ENTRADA_LIBERADA, bus.STATUS_DE_ESTRADA_BLOQUEADA, bus.STATUS_DE_FALHA,
             bus.ALGUM_BLOQUEIO, bus.ALGUMA_FALHA} !== 8'b0) begin
            bad++;
            $display("FAIL reset_outs: got lib=%b bloq=%b falha=%b want all 0",
                     bus.STATUS_DE_ENTRADA_LIBERADA, bus.STATUS_DE_ESTRADA_BLOQUEADA, bus.STATUS_DE_FALHA);
        end
        rst = 1'b0;
        tick(1);
        total++;
        if (bus.STATUS_DE_ENTRADA_LIBERADA !== 2'b11) begin
            bad++;
            $display("FAIL reset_passagem: got lib=%b want 11", bus.STATUS_DE_ENTRADA_LIBERADA);
        end
        tick(3);
        total++;
        if (bus.STATUS_DE_ENTRADA_LIBERADA !== 2'b11 || bus.STATUS_DE_ESTRADA_BLOQUEADA !== 2'b00) begin
            bad++;
            $display("FAIL reset_vigilancia: got lib=%b bloq=%b want 11/00",
                     bus.STATUS_DE_ENTRADA_LIBERADA, bus.STATUS_DE_ESTRADA_BLOQUEADA);
        end
    endtask

    task automatic test_bloqueio();
        bus.SENSOR_EXTERNO = 2'b01;
        tick(6);
        total++;
        if (bus.STATUS_DE_ESTRADA_BLOQUEADA !== 2'b00 || bus.STATUS_DE_ENTRADA_LIBERADA !== 2'b11) begin
            bad++;
            $display("FAIL bloq_early: got bloq=%b lib=%b want 00/11",
                     bus.STATUS_DE_ESTRADA_BLOQUEADA, bus.STATUS_DE_ENTRADA_LIBERADA);
        end
        tick(1);
        total++;
        if (bus.STATUS_DE_ESTRADA_BLOQUEADA !== 2'b01 || bus.STATUS_DE_ENTRADA_LIBERADA !== 2'b10
            || bus.ALGUM_BLOQUEIO !== 1'b1) begin
            bad++;
            $display("FAIL bloq_at7: got bloq=%b lib=%b any=%b want 01/10/1",
                     bus.STATUS_DE_ESTRADA_BLOQUEADA, bus.STATUS_DE_ENTRADA_LIBERADA, bus.ALGUM_BLOQUEIO);
        end
        bus.SENSOR_EXTERNO = 2'b00;
        tick(7);
        total++;
        if (bus.STATUS_DE_ESTRADA_BLOQUEADA !== 2'b00 || bus.STATUS_DE_ENTRADA_LIBERADA !== 2'b11
            || bus.ALGUM_BLOQUEIO !== 1'b0) begin
            bad++;
            $display("FAIL bloq_release: got bloq=%b lib=%b any=%b want 00/11/0",
                     bus.STATUS_DE_ESTRADA_BLOQUEADA, bus.STATUS_DE_ENTRADA_LIBERADA, bus.ALGUM_BLOQUEIO);
        end
    endtask

    task automatic test_glitch();
        int changed = 0;
        bus.SENSOR_EXTERNO = 2'b01;
        tick(3);
        bus.SENSOR_EXTERNO = 2'b00;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (bus.STATUS_DE_ESTRADA_BLOQUEADA !== 2'b00 || bus.STATUS_DE_ENTRADA_LIBERADA !== 2'b11)
                changed++;
        end
        total++;
        if (changed != 0) begin
            bad++;
            $display("FAIL glitch: got %0d disturbed cycles want 0", changed);
        end
    endtask

    task automatic test_falha();
        bus.SENSOR_EXTERNO = 2'b01;
        tick(22);
        total++;
        if (bus.STATUS_DE_FALHA !== 2'b00 || bus.STATUS_DE_ESTRADA_BLOQUEADA !== 2'b01) begin
            bad++;
            $display("FAIL falha_early: got falha=%b bloq=%b want 00/01",
                     bus.STATUS_DE_FALHA, bus.STATUS_DE_ESTRADA_BLOQUEADA);
        end
        tick(1);
        total++;
        if (bus.STATUS_DE_FALHA !== 2'b01 || bus.ALGUMA_FALHA !== 1'b1
            || bus.STATUS_DE_ESTRADA_BLOQUEADA !== 2'b01) begin
            bad++;
            $display("FAIL falha_set: got falha=%b any=%b bloq=%b want 01/1/01",
                     bus.STATUS_DE_FALHA, bus.ALGUMA_FALHA, bus.STATUS_DE_ESTRADA_BLOQUEADA);
        end
        bus.SENSOR_EXTERNO = 2'b00;
        tick(10);
        total++;
        if (bus.STATUS_DE_FALHA !== 2'b01 || bus.STATUS_DE_ESTRADA_BLOQUEADA !== 2'b01) begin
            bad++;
            $display("FAIL falha_sticky: got falha=%b bloq=%b want 01/01",
                     bus.STATUS_DE_FALHA, bus.STATUS_DE_ESTRADA_BLOQUEADA);
        end
        bus.ON_OFF = 1'b0;
        tick(1);
        total++;
        if ({bus.STATUS_DE_ENTRADA_LIBERADA, bus.STATUS_DE_ESTRADA_BLOQUEADA, bus.STATUS_DE_FALHA,
             bus.ALGUM_BLOQUEIO, bus.ALGUMA_FALHA} !== 8'b0) begin
            bad++;
            $display("FAIL onoff_off: got lib=%b bloq=%b falha=%b want all 0",
                     bus.STATUS_DE_ENTRADA_LIBERADA, bus.STATUS_DE_ESTRADA_BLOQUEADA, bus.STATUS_DE_FALHA);
        end
        bus.ON_OFF = 1'b1;
        tick(1);
        total++;
        if (bus.STATUS_DE_ENTRADA_LIBERADA !== 2'b11 || bus.STATUS_DE_FALHA !== 2'b00) begin
            bad++;
            $display("FAIL onoff_on: got lib=%b falha=%b want 11/00",
                     bus.STATUS_DE_ENTRADA_LIBERADA, bus.STATUS_DE_FALHA);
        end
        tick(1);
    endtask

    task automatic test_nova_passagem();
        bus.SENSOR_EXTERNO = 2'b10;
        tick(6);
        total++;
        if (bus.STATUS_DE_ENTRADA_LIBERADA !== 2'b11) begin
            bad++;
            $display("FAIL nova_pre: got lib=%b want 11", bus.STATUS_DE_ENTRADA_LIBERADA);
        end
        bus.NOVA_PASSAGEM = 2'b10;
        tick(1);
        bus.NOVA_PASSAGEM = 2'b00;
        total++;
        if (bus.STATUS_DE_ESTRADA_BLOQUEADA !== 2'b10 || bus.STATUS_DE_ENTRADA_LIBERADA !== 2'b01) begin
            bad++;
            $display("FAIL nova_vs_bloq: got bloq=%b lib=%b want 10/01",
                     bus.STATUS_DE_ESTRADA_BLOQUEADA, bus.STATUS_DE_ENTRADA_LIBERADA);
        end
        bus.NOVA_PASSAGEM = 2'b10;
        tick(1);
        bus.NOVA_PASSAGEM = 2'b00;
        total++;
        if (bus.STATUS_DE_ESTRADA_BLOQUEADA !== 2'b10) begin
            bad++;
            $display("FAIL nova_ignored: got bloq=%b want 10", bus.STATUS_DE_ESTRADA_BLOQUEADA);
        end
        bus.SENSOR_EXTERNO = 2'b00;
        tick(7);
        total++;
        if (bus.STATUS_DE_ENTRADA_LIBERADA !== 2'b11 || bus.STATUS_DE_ESTRADA_BLOQUEADA !== 2'b00) begin
            bad++;
            $display("FAIL nova_back: got lib=%b bloq=%b want 11/00",
                     bus.STATUS_DE_ENTRADA_LIBERADA, bus.STATUS_DE_ESTRADA_BLOQUEADA);
        end
        bus.NOVA_PASSAGEM = 2'b10;
        tick(1);
        bus.NOVA_PASSAGEM = 2'b00;
        total++;
        if (bus.STATUS_DE_ENTRADA_LIBERADA !== 2'b11) begin
            bad++;
            $display("FAIL nova_rearm: got lib=%b want 11", bus.STATUS_DE_ENTRADA_LIBERADA);
        end
        tick(2);
        total++;
        if (bus.STATUS_DE_ENTRADA_LIBERADA !== 2'b11 || bus.STATUS_DE_ESTRADA_BLOQUEADA !== 2'b00) begin
            bad++;
            $display("FAIL nova_settle: got lib=%b bloq=%b want 11/00",
                     bus.STATUS_DE_ENTRADA_LIBERADA, bus.STATUS_DE_ESTRADA_BLOQUEADA);
        end
    endtask

`ifdef CONTADOR_DE_BLOQUEIOS_EN
    task automatic test_contagem();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(2);
        total++;
        if (bus.CONTAGEM_BLOQUEIOS !== 16'h0000) begin
            bad++;
            $display("FAIL cnt_reset: got %h want 0000", bus.CONTAGEM_BLOQUEIOS);
        end
        for (int i = 0; i < 300; i++) begin
            bus.SENSOR_EXTERNO = 2'b10;
            tick(7);
            bus.SENSOR_EXTERNO = 2'b00;
            tick(7);
        end
        total++;
        if (bus.CONTAGEM_BLOQUEIOS !== 16'hFF00) begin
            bad++;
            $display("FAIL cnt_saturate: got %h want ff00", bus.CONTAGEM_BLOQUEIOS);
        end
        bus.ON_OFF = 1'b0;
        tick(1);
        bus.ON_OFF = 1'b1;
        tick(2);
        total++;
        if (bus.CONTAGEM_BLOQUEIOS !== 16'hFF00) begin
            bad++;
            $display("FAIL cnt_onoff: got %h want ff00", bus.CONTAGEM_BLOQUEIOS);
        end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        total++;
        if (bus.CONTAGEM_BLOQUEIOS !== 16'h0000) begin
            bad++;
            $display("FAIL cnt_rst: got %h want 0000", bus.CONTAGEM_BLOQUEIOS);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_bloqueio();
        test_glitch();
        test_falha();
        test_nova_passagem();
`ifdef CONTADOR_DE_BLOQUEIOS_EN
        test_contagem();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
